// File: rtl/expmul_acc.sv
// Streaming exp-weighted accumulator: rescales the running O/l sums by 2^-sh
// as the running max moves, and drains the finished O row slice by slice.

module expmul_lane #(
  parameter int DATA_W = 27,
  parameter int SH_W   = 7
)(
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] v,
  input  logic [SH_W-1:0]   sh_o,
  input  logic [SH_W-1:0]   sh_v,
  input  logic              first,
  output logic [DATA_W-1:0] res
);
  // Arithmetic shift, sign-extended by one bit; shifts past the width give 0.
  function automatic logic [DATA_W:0] shr(input logic [DATA_W-1:0] x,
                                          input logic [SH_W-1:0] sh);
    logic signed [DATA_W-1:0] xs;
    xs = x;
    if (32'(sh) >= DATA_W) return '0;
    return {xs[DATA_W-1], xs >>> sh};
  endfunction

  logic [DATA_W:0] t_o, t_v, sum;

  always_comb begin
    t_o = first ? '0 : shr(acc, sh_o);
    t_v = shr(v, sh_v);
    sum = t_o + t_v;
    if (sum[DATA_W] != sum[DATA_W-1])
      res = {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}};
    else
      res = sum[DATA_W-1:0];
  end
endmodule

module expmul_acc #(
  parameter int DIM     = 64,
  parameter int LANES   = 8,
  parameter int SCORE_W = 9,
  parameter int DATA_W  = 27
)(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld_in,
  output logic                           rdy_out,
  input  logic [SCORE_W-1:0]             s_in,
  input  logic                           first_in,
  input  logic                           last_in,
  input  logic [LANES-1:0][DATA_W-1:0]   v_in,
  output logic                           vld_out,
  input  logic                           rdy_in,
  output logic [LANES-1:0][DATA_W-1:0]   o_out,
  output logic [$clog2(DIM/LANES)-1:0]   o_beat_out,
  output logic [DATA_W-1:0]              l_out,
  output logic [SCORE_W-1:0]             m_out
);
  localparam int BEATS = DIM / LANES;
  localparam int BW    = $clog2(BEATS);
  localparam int DW    = SCORE_W + 1;
  localparam int YW    = DW + 5;
  localparam int SH_W  = YW - 8;
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1 << 17);

  typedef enum logic {ACC, DRAIN} state_t;

  // sh = round(-23*d/256), ties toward zero; d <= 0 so -d is a magnitude.
  function automatic logic [SH_W-1:0] shift_of(input logic signed [DW-1:0] d);
    logic [DW-1:0] nd;
    logic [YW-1:0] y;
    nd = -d;
    y  = (YW'(nd) << 4) + (YW'(nd) << 2) + (YW'(nd) << 1) + YW'(nd) + YW'(127);
    return y[YW-1:8];
  endfunction

  state_t                               state;
  logic [BW-1:0]                        beat_cnt, o_beat;
  logic [BEATS-1:0][LANES-1:0][DATA_W-1:0] o_mem;
  logic [DATA_W-1:0]                    l_acc;
  logic signed [SCORE_W-1:0]            m_acc;
  logic [SH_W-1:0]                      sh_o_q, sh_v_q;
  logic                                 first_q, last_q, force_first;

  logic                                 hs_in, beat0, first_c, first_e;
  logic signed [SCORE_W-1:0]            s_s, m_new;
  logic signed [DW-1:0]                 d_o, d_v;
  logic [SH_W-1:0]                      sh_o_c, sh_v_c, sh_o_e, sh_v_e;
  logic [LANES-1:0][DATA_W-1:0]         o_cur, o_new;
  logic [DATA_W-1:0]                    l_new;

  assign hs_in = vld_in && rdy_out;

  // Beat 0 derives the shifts live from s_in; later beats reuse the held copy.
  always_comb begin
    s_s     = s_in;
    first_c = first_in | force_first;
    m_new   = (first_c || s_s > m_acc) ? s_s : m_acc;
    d_o     = first_c ? '0 : {m_acc[SCORE_W-1], m_acc} - {m_new[SCORE_W-1], m_new};
    d_v     = {s_s[SCORE_W-1], s_s} - {m_new[SCORE_W-1], m_new};
    sh_o_c  = shift_of(d_o);
    sh_v_c  = shift_of(d_v);
    beat0   = (beat_cnt == '0);
    sh_o_e  = beat0 ? sh_o_c  : sh_o_q;
    sh_v_e  = beat0 ? sh_v_c  : sh_v_q;
    first_e = beat0 ? first_c : first_q;
    o_cur   = o_mem[beat_cnt];
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    expmul_lane #(.DATA_W(DATA_W), .SH_W(SH_W)) u_lane (
      .acc(o_cur[i]), .v(v_in[i]), .sh_o(sh_o_e), .sh_v(sh_v_e),
      .first(first_e), .res(o_new[i])
    );
  end

  expmul_lane #(.DATA_W(DATA_W), .SH_W(SH_W)) u_l (
    .acc(l_acc), .v(ONE), .sh_o(sh_o_c), .sh_v(sh_v_c),
    .first(first_c), .res(l_new)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ACC;
      beat_cnt    <= '0;
      o_beat      <= '0;
      o_mem       <= '0;
      l_acc       <= '0;
      m_acc       <= '0;
      sh_o_q      <= '0;
      sh_v_q      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      force_first <= 1'b1;
      vld_out     <= 1'b0;
      rdy_out     <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          rdy_out <= 1'b1;
          if (hs_in) begin
            o_mem[beat_cnt] <= o_new;
            if (beat0) begin
              l_acc       <= l_new;
              m_acc       <= m_new;
              sh_o_q      <= sh_o_c;
              sh_v_q      <= sh_v_c;
              first_q     <= first_c;
              last_q      <= last_in;
              force_first <= 1'b0;
            end
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              if (last_q) begin
                state   <= DRAIN;
                vld_out <= 1'b1;
                rdy_out <= 1'b0;
                o_beat  <= '0;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rdy_in) begin
            if (o_beat == LAST_BEAT) begin
              state       <= ACC;
              vld_out     <= 1'b0;
              rdy_out     <= 1'b1;
              o_beat      <= '0;
              force_first <= 1'b1;
            end else begin
              o_beat <= o_beat + 1'b1;
            end
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign o_out      = o_mem[o_beat];
  assign o_beat_out = o_beat;
  assign l_out      = l_acc;
  assign m_out      = m_acc;
endmodule
